// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic array with weight-load sequencer, valid/ready input
// handshake, input skew and output deskew. Each accepted activation vector yields y[c] = sum_r a[r]*W[r][c].
module systolic_array_ws #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 24
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [COLS*DW-1:0]   w_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ROWS*DW-1:0]   a_data,
  input  logic                 a_last,
  output logic                 o_valid,
  output logic [COLS*AW-1:0]   o_data,
  output logic                 o_last,
  output logic                 busy
);

  localparam int L   = ROWS + COLS - 1;
  localparam int PW  = 2 * DW;
  localparam int WCW = $clog2(ROWS + 1);
  localparam int DCW = $clog2(L + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           w_acc, a_acc;

  // Readies are held low while RESET is asserted so nothing is accepted during reset.
  assign w_ready = !RESET && (state_q == S_IDLE || state_q == S_LOAD);
  assign a_ready = !RESET && (state_q == S_COMPUTE);
  assign busy    = (state_q != S_IDLE);
  assign w_acc   = w_valid && w_ready;
  assign a_acc   = a_valid && a_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns every next-state signal; no latches.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (w_acc) begin
          if (wcnt_q == WCW'(ROWS - 1)) begin
            state_d = S_COMPUTE;
            wcnt_d  = '0;
          end else begin
            state_d = S_LOAD;
            wcnt_d  = wcnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (a_acc && a_last) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      default: begin
        if (dcnt_q == DCW'(L - 1)) state_d = S_IDLE;
        else                       dcnt_d  = dcnt_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking for all clocked state so evaluation order between blocks never matters.
    if (RESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Weight columns shift down one row per accepted beat; row 0 takes the new beat.
  logic signed [DW-1:0] w_q [ROWS][COLS];

  always_ff @(posedge CLK) begin
    // NOTE: weights are plain flops, not a RAM macro, so clearing them on reset is legal and cheap.
    if (RESET) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
    end else if (w_acc) begin
      for (int c = 0; c < COLS; c++) w_q[0][c] <= w_data[c*DW +: DW];
      for (int r = 1; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_q[r][c] <= w_q[r-1][c];
    end
  end

  // Input skew: row r sees its element r cycles after acceptance.
  logic signed [DW-1:0] row_a [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign row_a[r] = a_data[0 +: DW];
    end else begin : g_regs
      logic signed [DW-1:0] sk_q [r];
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int j = 0; j < r; j++) sk_q[j] <= '0;
        end else begin
          sk_q[0] <= a_data[r*DW +: DW];
          for (int j = 1; j < r; j++) sk_q[j] <= sk_q[j-1];
        end
      end
      assign row_a[r] = sk_q[r-1];
    end
  end

  logic signed [DW-1:0] act_w [ROWS][COLS];
  logic signed [AW-1:0] ps_w  [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [DW-1:0] a_in, act_q;
      logic signed [AW-1:0] p_in, ps_q;
      logic signed [PW-1:0] prod;

      if (c == 0) begin : g_a_edge
        assign a_in = row_a[r];
      end else begin : g_a_link
        assign a_in = act_w[r][c-1];
      end
      if (r == 0) begin : g_p_edge
        assign p_in = '0;
      end else begin : g_p_link
        assign p_in = ps_w[r-1][c];
      end

      assign prod = PW'(a_in) * PW'(w_q[r][c]);

      always_ff @(posedge CLK) begin
        if (RESET) begin
          act_q <= '0;
          ps_q  <= '0;
        end else begin
          act_q <= a_in;
          ps_q  <= p_in + AW'(prod);
        end
      end

      assign act_w[r][c] = act_q;
      assign ps_w[r][c]  = ps_q;
    end
  end

  // Output deskew: column c waits COLS-1-c cycles so all columns of one beat line up.
  logic signed [AW-1:0] col_y [COLS];

  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    if (c == COLS - 1) begin : g_direct
      assign col_y[c] = ps_w[ROWS-1][c];
    end else begin : g_regs
      localparam int N = COLS - 1 - c;
      logic signed [AW-1:0] dk_q [N];
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int j = 0; j < N; j++) dk_q[j] <= '0;
        end else begin
          dk_q[0] <= ps_w[ROWS-1][c];
          for (int j = 1; j < N; j++) dk_q[j] <= dk_q[j-1];
        end
      end
      assign col_y[c] = dk_q[N-1];
    end
  end

  logic [L-1:0]       vld_q, lst_q;
  logic               o_valid_q, o_last_q;
  logic [COLS*AW-1:0] o_data_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_q     <= '0;
      lst_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      vld_q     <= (vld_q << 1) | L'(a_acc);
      lst_q     <= (lst_q << 1) | L'(a_acc && a_last);
      o_valid_q <= vld_q[L-1];
      o_last_q  <= vld_q[L-1] && lst_q[L-1];
      if (vld_q[L-1]) begin
        for (int c = 0; c < COLS; c++) o_data_q[c*AW +: AW] <= col_y[c];
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_data  = o_data_q;

endmodule
